// File: rtl/fpu_busif_pkg.sv
// ============================================================================
// Module   : pa_fpu (package)
// Purpose  : Operation codes, register map and controller states for fpu_busif
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pa_fpu;

    typedef enum logic [7:0] {
        op_add = 8'h00,
        op_sub = 8'h01,
        op_mul = 8'h02,
        op_div = 8'h03
    } e_fpu_operations;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } e_busif_state;

    localparam logic [3:0] FPU_ADDR_OPA0  = 4'h0;
    localparam logic [3:0] FPU_ADDR_OPA1  = 4'h1;
    localparam logic [3:0] FPU_ADDR_OPA2  = 4'h2;
    localparam logic [3:0] FPU_ADDR_OPA3  = 4'h3;
    localparam logic [3:0] FPU_ADDR_OPB0  = 4'h4;
    localparam logic [3:0] FPU_ADDR_OPB1  = 4'h5;
    localparam logic [3:0] FPU_ADDR_OPB2  = 4'h6;
    localparam logic [3:0] FPU_ADDR_OPB3  = 4'h7;
    localparam logic [3:0] FPU_ADDR_OPER  = 4'h8;
    localparam logic [3:0] FPU_ADDR_START = 4'h9;
    // Result bytes share address 9 with the start command (read vs. write)
    localparam logic [3:0] FPU_ADDR_RES0   = 4'h9;
    localparam logic [3:0] FPU_ADDR_RES1   = 4'hA;
    localparam logic [3:0] FPU_ADDR_RES2   = 4'hB;
    localparam logic [3:0] FPU_ADDR_RES3   = 4'hC;
    localparam logic [3:0] FPU_ADDR_STATUS = 4'hD;

    localparam logic [31:0] FPU_TIMEOUT_RESULT = 32'h7FC00000;
    localparam logic [7:0]  FPU_TIMEOUT_LAST   = 8'd254;

endpackage

`default_nettype wire

// File: rtl/fpu_busif.sv
// ============================================================================
// Module   : fpu_busif
// Purpose  : 8-bit host bus register file and command sequencer for an FPU core.
//            Optional RUN watchdog enabled by defining FPU_BUSIF_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_busif
    import pa_fpu::*;
(
    input  logic            clk,
    input  logic            arst,
    input  logic [7:0]      databus_in,
    output logic [7:0]      databus_out,
    input  logic [3:0]      addr,
    input  logic            cs,
    input  logic            rd,
    input  logic            wr,
    input  logic            end_ack,
    output logic            cmd_end,
    output logic            busy,
    output logic [31:0]     op_a,
    output logic [31:0]     op_b,
    output e_fpu_operations operation,
    output logic            start,
    input  logic            core_done,
    input  logic [31:0]     core_result
);

    e_busif_state    r_state;
    e_busif_state    w_state_nxt;
    logic            r_wr_prev;
    logic [31:0]     r_op_a;
    logic [31:0]     r_op_b;
    logic [31:0]     r_result;
    e_fpu_operations r_operation;
    logic            r_start;
    logic            w_strobe;
    logic            w_start_strobe;
    logic            w_done_hit;
    logic            w_err;
    logic            w_timeout;

    assign w_strobe       = r_wr_prev & ~wr & ~cs;
    assign w_start_strobe = w_strobe && (addr == FPU_ADDR_START);
    assign w_done_hit     = (r_state == ST_RUN) && core_done;

`ifdef FPU_BUSIF_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_err;

    // Fires on the 255th consecutive RUN cycle without a core_done
    assign w_timeout = (r_state == ST_RUN) && !core_done && (r_tmo_cnt == FPU_TIMEOUT_LAST);
    assign w_err     = r_err;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_tmo_cnt <= 8'd0;
            r_err     <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == ST_RUN) ? r_tmo_cnt + 8'd1 : 8'd0;
            if (w_start_strobe && r_state == ST_IDLE)
                r_err <= 1'b0;
            else if (w_timeout)
                r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (arst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start_strobe)            w_state_nxt = ST_RUN;
            ST_RUN:  if (core_done || w_timeout)    w_state_nxt = ST_DONE;
            ST_DONE: if (end_ack)                   w_state_nxt = ST_IDLE;
            default:                                w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state == ST_RUN);
        cmd_end = (r_state == ST_DONE);
    end

    // Register writes are accepted only while the controller is idle
    always_ff @(posedge clk) begin
        if (arst) begin
            r_wr_prev   <= 1'b1;
            r_op_a      <= 32'd0;
            r_op_b      <= 32'd0;
            r_operation <= op_add;
            r_result    <= 32'd0;
            r_start     <= 1'b0;
        end else begin
            r_wr_prev <= wr;
            r_start   <= 1'b0;
            if (w_strobe && r_state == ST_IDLE) begin
                if (addr[3:2] == 2'b00)
                    r_op_a[{addr[1:0], 3'b000} +: 8] <= databus_in;
                else if (addr[3:2] == 2'b01)
                    r_op_b[{addr[1:0], 3'b000} +: 8] <= databus_in;
                else if (addr == FPU_ADDR_OPER)
                    r_operation <= e_fpu_operations'(databus_in);
                else if (addr == FPU_ADDR_START)
                    r_start <= 1'b1;
            end
            if (w_done_hit)
                r_result <= core_result;
            else if (w_timeout)
                r_result <= FPU_TIMEOUT_RESULT;
        end
    end

    always_comb begin
        databus_out = 8'h00;
        if (!cs && !rd) begin
            case (addr)
                FPU_ADDR_OPA0, FPU_ADDR_OPA1, FPU_ADDR_OPA2, FPU_ADDR_OPA3:
                    databus_out = r_op_a[{addr[1:0], 3'b000} +: 8];
                FPU_ADDR_OPB0, FPU_ADDR_OPB1, FPU_ADDR_OPB2, FPU_ADDR_OPB3:
                    databus_out = r_op_b[{addr[1:0], 3'b000} +: 8];
                FPU_ADDR_OPER:   databus_out = r_operation;
                FPU_ADDR_RES0:   databus_out = r_result[7:0];
                FPU_ADDR_RES1:   databus_out = r_result[15:8];
                FPU_ADDR_RES2:   databus_out = r_result[23:16];
                FPU_ADDR_RES3:   databus_out = r_result[31:24];
                FPU_ADDR_STATUS: databus_out = {5'b0, w_err, busy, cmd_end};
                default:         databus_out = 8'h00;
            endcase
        end
    end

    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign operation = r_operation;
    assign start     = r_start;

endmodule

`default_nettype wire
